deframing: RTL and testbench

Receive end of the framed-sample stream: captures elements presented in the hold-for-`CADENCE_CYC` framing protocol (continuous `valid_i`, data changes every `CADENCE_CYC` cycles, `last_i` on the frame's final element) and re-serialises them as a slow, evenly spaced sample stream with one-cycle valid strobes. It sits on the return path of the acoustic front end, between a frame-based processing stage and a sample-rate consumer. It also checks frame length and flags protocol errors.

---
 rtl/deframing_pkg.sv | 21 ++
 rtl/deframing_if.sv | 25 ++
 rtl/deframing_fifo.sv | 56 +++++
 rtl/deframing.sv | 142 ++++++++++++++
 tb/tb_deframing.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/deframing_pkg.sv
// Shared definitions for the deframing receive path: Rx FSM encoding and the
// saturating width-reduction helper reused by other narrowing stages.
package deframing_pkg;

   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_FRAME = 1'b1
   } rx_state_e;

   // Clamp a sign-extended value into the range of an ob-bit signed word.
   function automatic logic signed [31:0] sat_narrow(input logic signed [31:0] x, input int ob);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (ob - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
      if (x > hi) return hi;
      if (x < lo) return lo;
      return x;
   endfunction

endpackage

// File: rtl/deframing_if.sv
// Framed element stream in, paced sample stream and status pulses out.
// slave = deframing block side, master = producer/consumer side.
interface deframing_if #(
   parameter int I_BW = 16,
   parameter int O_BW = 9
);
   logic signed [I_BW-1:0] data_i;
   logic                   valid_i;
   logic                   last_i;
   logic signed [O_BW-1:0] data_o;
   logic                   valid_o;
   logic                   last_o;
   logic                   frame_err_o;
   logic                   overflow_o;

   modport slave (
      input  data_i, valid_i, last_i,
      output data_o, valid_o, last_o, frame_err_o, overflow_o
   );

   modport master (
      output data_i, valid_i, last_i,
      input  data_o, valid_o, last_o, frame_err_o, overflow_o
   );
endinterface

// File: rtl/deframing_fifo.sv
// Synchronous show-ahead FIFO of arbitrary depth; rd_data_o shows the head
// entry whenever empty_o is low. Writes when full and reads when empty are ignored.
module fifo #(
   parameter int DATA_WIDTH = 17,
   parameter int FIFO_DEPTH = 260
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  wr_en_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  full_o,
   output logic                  empty_o
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  do_wr, do_rd;

   assign full_o    = (cnt_q == CW'(FIFO_DEPTH));
   assign empty_o   = (cnt_q == '0);
   assign do_wr     = wr_en_i & ~full_o;
   assign do_rd     = rd_en_i & ~empty_o;
   assign rd_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_wr) wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      if (do_wr && !do_rd)      cnt_d = cnt_q + CW'(1);
      else if (!do_wr && do_rd) cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end
endmodule

// File: rtl/deframing.sv
// deframing: captures hold-for-CADENCE_CYC framed elements, checks frame length,
// and replays them every OUT_PERIOD cycles. `DEFRAMING_SAT_EN selects saturating narrowing.
module deframing
   import deframing_pkg::*;
#(
   parameter int I_BW        = 16,
   parameter int O_BW        = 9,
   parameter int FRAME_LEN   = 256,
   parameter int CADENCE_CYC = 3,
   parameter int OUT_PERIOD  = 8,
   parameter int FIFO_DEPTH  = 260
) (
   input  logic      clk_i,
   input  logic      rst_n_i,
   input  logic      en_i,
   deframing_if.slave bus
);
   localparam int CW = (CADENCE_CYC > 1) ? $clog2(CADENCE_CYC) : 1;
   localparam int EW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int PW = (OUT_PERIOD > 1) ? $clog2(OUT_PERIOD) : 1;

   logic [CW-1:0]          cap_cnt_q, cap_cnt_d;
   logic [EW-1:0]          elem_idx_q, elem_idx_d;
   logic [PW-1:0]          per_cnt_q, per_cnt_d;
   rx_state_e              state_q, state_d;
   logic signed [O_BW-1:0] data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   last_q, last_d;
   logic                   frame_err_q, frame_err_d;
   logic                   overflow_q, overflow_d;

   logic                   cap, len_bad, fall, tick, deq;
   logic                   fifo_full, fifo_empty, fifo_rst_n;
   logic [I_BW:0]          fifo_rd;
   logic signed [I_BW-1:0] rd_data;
   logic signed [O_BW-1:0] conv;
`ifdef DEFRAMING_SAT_EN
   logic signed [31:0]     sat_val;
`endif

   assign cap     = en_i & bus.valid_i & (cap_cnt_q == CW'(CADENCE_CYC - 1));
   assign len_bad = cap & (bus.last_i ? (elem_idx_q != EW'(FRAME_LEN - 1))
                                      : (elem_idx_q == EW'(FRAME_LEN - 1)));
   // A frame abandoned by valid_i dropping is an error; idle gaps between frames are not.
   assign fall    = en_i & (state_q == RX_FRAME) & ~bus.valid_i;
   assign tick    = en_i & (per_cnt_q == PW'(OUT_PERIOD - 1));
   assign deq     = tick & ~fifo_empty;
   assign fifo_rst_n = rst_n_i & en_i;
   assign rd_data = fifo_rd[I_BW-1:0];

   always_comb begin
`ifdef DEFRAMING_SAT_EN
      sat_val = sat_narrow(32'(rd_data), O_BW);
      conv    = O_BW'(sat_val);
`else
      conv    = O_BW'(rd_data);
`endif
   end

   // Rx FSM: state register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= RX_IDLE;
      else          state_q <= state_d;
   end

   // Rx FSM: next state
   always_comb begin
      state_d = state_q;
      if (!en_i) begin
         state_d = RX_IDLE;
      end else begin
         case (state_q)
            RX_IDLE:  if (cap && !bus.last_i) state_d = RX_FRAME;
            RX_FRAME: if (!bus.valid_i || (cap && bus.last_i)) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
         endcase
      end
   end

   // Rx FSM: outputs (length tracking and error pulse)
   always_comb begin
      frame_err_d = len_bad | fall;
      elem_idx_d  = elem_idx_q;
      if (!en_i || fall)              elem_idx_d = '0;
      else if (cap && (bus.last_i || len_bad)) elem_idx_d = '0;
      else if (cap)                   elem_idx_d = elem_idx_q + EW'(1);
   end

   always_comb begin
      cap_cnt_d  = cap_cnt_q + CW'(1);
      if (!en_i || !bus.valid_i || cap) cap_cnt_d = '0;
      per_cnt_d  = per_cnt_q + PW'(1);
      if (!en_i || tick) per_cnt_d = '0;
      valid_d    = deq;
      last_d     = deq & fifo_rd[I_BW];
      data_d     = deq ? conv : data_q;
      if (!en_i) data_d = '0;
      overflow_d = cap & fifo_full;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cap_cnt_q   <= '0;
         elem_idx_q  <= '0;
         per_cnt_q   <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         cap_cnt_q   <= cap_cnt_d;
         elem_idx_q  <= elem_idx_d;
         per_cnt_q   <= per_cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   fifo #(
      .DATA_WIDTH (I_BW + 1),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_n_i   (fifo_rst_n),
      .wr_en_i   (cap),
      .wr_data_i ({bus.last_i, bus.data_i}),
      .rd_en_i   (deq),
      .rd_data_o (fifo_rd),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign bus.data_o      = data_q;
   assign bus.valid_o     = valid_q;
   assign bus.last_o      = last_q;
   assign bus.frame_err_o = frame_err_q;
   assign bus.overflow_o  = overflow_q;
endmodule

// File: tb/tb_deframing.sv
// Scoreboard bench for deframing: stimulus feeds an element-level reference model
// that queues expected strobes/pulses with their cycle stamps; a monitor checks them.
module tb_deframing;
   localparam int I_BW        = 16;
   localparam int O_BW        = 9;
   localparam int FRAME_LEN   = 4;
   localparam int CADENCE_CYC = 3;
   localparam int OUT_PERIOD  = 8;
   localparam int FIFO_DEPTH  = 6;

   logic clk = 1'b0;
   logic rst_n;
   logic en;

   deframing_if #(.I_BW(I_BW), .O_BW(O_BW)) bus ();

   deframing #(
      .I_BW(I_BW), .O_BW(O_BW), .FRAME_LEN(FRAME_LEN), .CADENCE_CYC(CADENCE_CYC),
      .OUT_PERIOD(OUT_PERIOD), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct { int cyc; int d; bit l; } exp_t;
   typedef struct { int d; bit l; } elem_t;

   exp_t  exp_out[$];
   int    exp_err[$];
   int    exp_ovf[$];
   elem_t mq[$];
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   int    hold_d = 0;
   int    ph = 0;
   int    idx = 0;
   int    strobes = 0;
   bit    in_frame = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int conv(int x);
      int m;
      int r;
`ifdef DEFRAMING_SAT_EN
      m = 1 << (O_BW - 1);
      if (x > m - 1) return m - 1;
      if (x < -m) return -m;
      return x;
`else
      m = 1 << O_BW;
      r = x % m;
      if (r < 0) r += m;
      if (r >= m / 2) r -= m;
      return r;
`endif
   endfunction

   task automatic chk(string nm, int act, int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic clear_model();
      mq.delete();
      ph = 0;
      idx = 0;
      in_frame = 0;
      hold_d = 0;
   endtask

   // Reference behaviour for the coming clock edge (edge number cyc+1).
   task automatic model(bit e, bit v, int d, bit l, bit capt);
      bit    tick;
      bit    bad;
      int    pre;
      exp_t  x;
      elem_t el;
      if (!e) begin
         clear_model();
         return;
      end
      tick = (ph == OUT_PERIOD - 1);
      ph   = (ph + 1) % OUT_PERIOD;
      pre  = mq.size();
      if (tick && pre > 0) begin
         x.cyc = cyc + 1;
         x.d   = conv(mq[0].d);
         x.l   = mq[0].l;
         exp_out.push_back(x);
         void'(mq.pop_front());
      end
      if (capt) begin
         if (pre >= FIFO_DEPTH) exp_ovf.push_back(cyc + 1);
         else begin
            el.d = d;
            el.l = l;
            mq.push_back(el);
         end
         bad = l ? (idx != FRAME_LEN - 1) : (idx == FRAME_LEN - 1);
         if (bad) exp_err.push_back(cyc + 1);
         idx = (l || bad) ? 0 : idx + 1;
         in_frame = !l;
      end else if (!v && in_frame) begin
         exp_err.push_back(cyc + 1);
         in_frame = 0;
         idx = 0;
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic step(bit e, bit v, int d, bit l, bit capt);
      logic [15:0] t;
      t = d[15:0];
      en = e;
      bus.valid_i = v;
      bus.data_i  = t;
      bus.last_i  = l;
      #1;
      model(e, v, int'($signed(t)), l, capt);
      @(negedge clk);
   endtask

   task automatic send_elem(int d, bit l);
      for (int k = 0; k < CADENCE_CYC; k++) step(1, 1, d, l, k == CADENCE_CYC - 1);
   endtask

   task automatic idle(int n);
      repeat (n) step(1, 0, 0, 0, 0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((mq.size() > 0 || exp_out.size() > 0) && n < 400) begin
         idle(1);
         n++;
      end
      idle(2);
      chk("drain_timeout", (n < 400) ? 1 : 0, 1);
   endtask

   task automatic chk_zero_outputs(string nm);
      chk({nm, "_data"}, int'($signed(bus.data_o)), 0);
      chk({nm, "_valid"}, int'(bus.valid_o), 0);
      chk({nm, "_last"}, int'(bus.last_o), 0);
      chk({nm, "_frame_err"}, int'(bus.frame_err_o), 0);
      chk({nm, "_overflow"}, int'(bus.overflow_o), 0);
   endtask

   // Called at a falling edge; asserts reset asynchronously between edges.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      bus.valid_i = 1'b0;
      #1;
      chk_zero_outputs("async_reset");
      clear_model();
      exp_out.delete();
      exp_err.delete();
      exp_ovf.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t m;
      if (bus.valid_o) begin
         checks++;
         strobes++;
         if (exp_out.size() == 0 || exp_out[0].cyc != cyc) begin
            errors++;
            $display("FAIL strobe_unexpected cycle=%0d data=%0d", cyc, $signed(bus.data_o));
         end else begin
            m = exp_out.pop_front();
            hold_d = m.d;
            if (int'($signed(bus.data_o)) != m.d || bus.last_o != m.l) begin
               errors++;
               $display("FAIL strobe_data cycle=%0d actual=%0d/%0b expected=%0d/%0b",
                        cyc, $signed(bus.data_o), bus.last_o, m.d, m.l);
            end
         end
      end else begin
         if (exp_out.size() > 0 && exp_out[0].cyc == cyc) begin
            checks++;
            errors++;
            $display("FAIL strobe_missing cycle=%0d expected=%0d", cyc, exp_out[0].d);
            void'(exp_out.pop_front());
         end
         checks++;
         if (int'($signed(bus.data_o)) != hold_d || bus.last_o) begin
            errors++;
            $display("FAIL hold cycle=%0d actual=%0d/%0b expected=%0d/0",
                     cyc, $signed(bus.data_o), bus.last_o, hold_d);
         end
      end
      if (bus.frame_err_o) begin
         checks++;
         if (exp_err.size() > 0 && exp_err[0] == cyc) void'(exp_err.pop_front());
         else begin
            errors++;
            $display("FAIL frame_err_unexpected cycle=%0d actual=1 expected=0", cyc);
         end
      end else if (exp_err.size() > 0 && exp_err[0] == cyc) begin
         checks++;
         errors++;
         $display("FAIL frame_err_missing cycle=%0d actual=0 expected=1", cyc);
         void'(exp_err.pop_front());
      end
      if (bus.overflow_o) begin
         checks++;
         if (exp_ovf.size() > 0 && exp_ovf[0] == cyc) void'(exp_ovf.pop_front());
         else begin
            errors++;
            $display("FAIL overflow_unexpected cycle=%0d actual=1 expected=0", cyc);
         end
      end else if (exp_ovf.size() > 0 && exp_ovf[0] == cyc) begin
         checks++;
         errors++;
         $display("FAIL overflow_missing cycle=%0d actual=0 expected=1", cyc);
         void'(exp_ovf.pop_front());
      end
   end

   initial begin
      int len;
      int s0;
      bit drop;
      bit l;
      rst_n = 1'b0;
      en = 1'b0;
      bus.valid_i = 1'b0;
      bus.data_i = '0;
      bus.last_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk_zero_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // clean frame 1..4
      for (int i = 1; i <= 4; i++) send_elem(i, i == 4);
      drain();

      // short frame (last on 3rd), then a clean frame
      for (int i = 1; i <= 3; i++) send_elem(i, i == 3);
      for (int i = 5; i <= 8; i++) send_elem(i, i == 8);
      drain();

      // out-of-range values for the narrowing
      send_elem(300, 0);  send_elem(-300, 0); send_elem(256, 0);   send_elem(-257, 1);
      send_elem(255, 0);  send_elem(-256, 0); send_elem(32767, 0); send_elem(-32768, 1);
      drain();

      // back-to-back frames overrun the buffer
      for (int f = 0; f < 4; f++)
         for (int k = 0; k < FRAME_LEN; k++) send_elem(100 * f + k, k == FRAME_LEN - 1);
      drain();

      // randomized frames: random lengths, gaps, missing last, abandoned frames
      for (int f = 0; f < 30; f++) begin
         len  = $urandom_range(1, 6);
         drop = ($urandom_range(0, 7) == 0);
         for (int k = 0; k < len; k++) begin
            l = (k == len - 1) && !drop && ($urandom_range(0, 5) != 0);
            send_elem($urandom_range(0, 65535), l);
         end
         if (drop) idle(1);
         else idle($urandom_range(0, 2));
         if ($urandom_range(0, 4) == 0) drain();
      end
      drain();

      // reset mid-frame, then a fresh frame
      send_elem(9, 0);
      send_elem(10, 0);
      do_reset();
      for (int i = 11; i <= 14; i++) send_elem(i, i == 14);
      drain();

      // enable dropped mid-drain clears the buffer
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < FRAME_LEN; k++) send_elem(20 + 4 * f + k, k == FRAME_LEN - 1);
      idle(10);
      step(0, 0, 0, 0, 0);
      #1;
      chk("en_clear_valid", int'(bus.valid_o), 0);
      chk("en_clear_data", int'($signed(bus.data_o)), 0);
      s0 = strobes;
      idle(5 * OUT_PERIOD);
      chk("en_clear_no_strobe", strobes - s0, 0);
      for (int i = 40; i <= 43; i++) send_elem(i, i == 43);
      drain();

      chk("queues_empty", exp_out.size() + exp_err.size() + exp_ovf.size() + mq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
